// File: rtl/result_banner.sv
// End-of-game text renderer for the VGA XO display.
// Draws "TIE", "X WIN" or "O WIN" from a 5x7 font scaled by 2^SCALE_LOG2.
// The text slides up into its settled position, then optionally blinks.
// draw is registered: it reflects the scan position presented one clock earlier.
module result_banner #(
  parameter int SCALE_LOG2   = 2,
  parameter int SLIDE_START  = 64,
  parameter int SLIDE_STEP   = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       show,
  input  logic [1:0] result,
  input  logic [9:0] scan_x,
  input  logic [8:0] scan_y,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic       draw,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLIDE = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam logic [10:0] START_OFF  = 11'(SLIDE_START);
  localparam logic [10:0] STEP_OFF   = 11'(SLIDE_STEP);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES > 0 ? BLINK_FRAMES - 1 : 0);

  // Glyph codes used to index the font
  localparam logic [2:0] G_SP = 3'd0;
  localparam logic [2:0] G_T  = 3'd1;
  localparam logic [2:0] G_I  = 3'd2;
  localparam logic [2:0] G_E  = 3'd3;
  localparam logic [2:0] G_X  = 3'd4;
  localparam logic [2:0] G_O  = 3'd5;
  localparam logic [2:0] G_W  = 3'd6;
  localparam logic [2:0] G_N  = 3'd7;

  state_e      state_q, state_d;
  logic [10:0] offset_q, offset_d;
  logic        visible_q, visible_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic [1:0]  word_q, word_d;
  logic        draw_q, draw_d;

  // Character code at position ch of the latched word (space beyond the end)
  function automatic logic [2:0] glyph_at(input logic [1:0] w, input logic [2:0] ch);
    logic [2:0] g;
    g = G_SP;
    if (w == 2'd3) begin
      case (ch)
        3'd0:    g = G_T;
        3'd1:    g = G_I;
        3'd2:    g = G_E;
        default: g = G_SP;
      endcase
    end else if (w != 2'd0) begin
      case (ch)
        3'd0:    g = (w == 2'd1) ? G_X : G_O;
        3'd2:    g = G_W;
        3'd3:    g = G_I;
        3'd4:    g = G_N;
        default: g = G_SP;
      endcase
    end
    return g;
  endfunction

  // One 5-bit font row; bit 4 is the leftmost column, row 0 is the top
  function automatic logic [4:0] glyph_row(input logic [2:0] g, input logic [2:0] r);
    logic [34:0] bm;
    logic [34:0] sh;
    case (g)
      G_T:     bm = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
      G_I:     bm = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      G_E:     bm = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      G_X:     bm = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11};
      G_O:     bm = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      G_W:     bm = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A};
      G_N:     bm = {5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11, 5'h11};
      default: bm = '0;
    endcase
    sh = bm >> (5 * (6 - int'(r)));
    return sh[4:0];
  endfunction

  // State register and banner bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      offset_q    <= START_OFF;
      visible_q   <= 1'b1;
      blink_cnt_q <= '0;
      word_q      <= 2'd0;
      draw_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      visible_q   <= visible_d;
      blink_cnt_q <= blink_cnt_d;
      word_q      <= word_d;
      draw_q      <= draw_d;
    end
  end

  // Next state: dropping show wins over everything, including a frame tick
  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    visible_d   = visible_q;
    blink_cnt_d = blink_cnt_q;
    word_d      = word_q;
    if (!show) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (result != 2'd0) begin
            word_d      = result;
            offset_d    = START_OFF;
            visible_d   = 1'b1;
            blink_cnt_d = '0;
            state_d     = (START_OFF == 11'd0) ? ST_SHOW : ST_SLIDE;
          end
        end
        ST_SLIDE: begin
          if (frame_tick) begin
            if (offset_q <= STEP_OFF) begin
              offset_d = '0;
              state_d  = ST_SHOW;
            end else begin
              offset_d = offset_q - STEP_OFF;
            end
          end
        end
        ST_SHOW: begin
          if ((BLINK_FRAMES > 0) && frame_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_d = '0;
              visible_d   = ~visible_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 16'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Pixel lookup for the current scan position (11-bit, no wrap)
  logic [10:0] ty, sx, sy, dx, dy, dx_s, ch, py;
  logic [2:0]  px, word_len, glyph;
  logic [4:0]  row_bits, row_sh;
  logic        hit, pixel_on;

  always_comb begin
    ty       = {2'b00, y} + offset_q;
    sx       = {1'b0, scan_x};
    sy       = {2'b00, scan_y};
    hit      = (sx >= {1'b0, x}) && (sy >= ty);
    dx       = sx - {1'b0, x};
    dy       = sy - ty;
    dx_s     = dx >> SCALE_LOG2;
    ch       = dx_s >> 3;
    px       = dx_s[2:0];
    py       = dy >> SCALE_LOG2;
    word_len = (word_q == 2'd3) ? 3'd3 : ((word_q == 2'd0) ? 3'd0 : 3'd5);
    glyph    = glyph_at(word_q, ch[2:0]);
    row_bits = glyph_row(glyph, py[2:0]);
    row_sh   = row_bits >> (3'd4 - px);
    pixel_on = hit && (ch < {8'b0, word_len}) && (px < 3'd5) && (py < 11'd7) && row_sh[0];
    draw_d   = (state_q != ST_IDLE) && visible_q && pixel_on;
  end

  assign draw = draw_q;
  assign busy = (state_q == ST_SLIDE);

endmodule

// File: tb/tb_result_banner.sv
// Bench for result_banner: directed phases with randomized scan probes checked
// against a reference model built from word strings, tick counts and the font table.
module tb_result_banner;

  localparam int X0    = 100;
  localparam int Y0    = 200;
  localparam int SC    = 4;
  localparam int START = 64;
  localparam int STEP  = 4;
  localparam int BLINK = 30;
  localparam int NSLIDE = (START + STEP - 1) / STEP;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       show = 1'b0;
  logic [1:0] result = 2'd0;
  logic [9:0] scan_x = '0;
  logic [8:0] scan_y = '0;
  logic [9:0] x = 10'(X0);
  logic [8:0] y = 9'(Y0);
  logic       draw;
  logic       busy;

  int tests = 0;
  int fails = 0;
  logic [0:0] exp_q[$];

  // model state
  bit    m_active = 1'b0;
  string m_word = "";
  int    m_t = 0;

  result_banner #(
    .SCALE_LOG2(2), .SLIDE_START(START), .SLIDE_STEP(STEP), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .show(show), .result(result),
    .scan_x(scan_x), .scan_y(scan_y), .x(x), .y(y), .draw(draw), .busy(busy)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_offset();
    return (m_t < NSLIDE) ? START - m_t * STEP : 0;
  endfunction

  function automatic bit m_busy();
    return m_active && (m_t < NSLIDE);
  endfunction

  function automatic bit m_visible();
    if (m_t <= NSLIDE) return 1'b1;
    return (((m_t - NSLIDE) / BLINK) % 2) == 0;
  endfunction

  function automatic logic [4:0] font_row(byte c, int r);
    logic [55:0] g;
    case (c)
      "T":     g = 56'h1F_04_04_04_04_04_04;
      "I":     g = 56'h0E_04_04_04_04_04_0E;
      "E":     g = 56'h1F_10_10_1E_10_10_1F;
      "X":     g = 56'h11_11_0A_04_0A_11_11;
      "O":     g = 56'h0E_11_11_11_11_11_0E;
      "W":     g = 56'h11_11_11_15_15_15_0A;
      "N":     g = 56'h11_19_15_13_11_11_11;
      default: g = 56'h0;
    endcase
    return g[(6 - r) * 8 +: 5];
  endfunction

  function automatic logic model_draw(int sx, int sy);
    int ty, dx, dy, ch, px, py;
    logic [4:0] row;
    if (!m_active || !m_visible()) return 1'b0;
    ty = Y0 + m_offset();
    if (sx < X0 || sy < ty) return 1'b0;
    dx = sx - X0;
    dy = sy - ty;
    ch = dx / (8 * SC);
    px = (dx / SC) % 8;
    py = dy / SC;
    if (ch >= m_word.len() || px >= 5 || py >= 7) return 1'b0;
    row = font_row(m_word[ch], py);
    return row[4 - px];
  endfunction

  // ---------------- checking ----------------
  task automatic check(string tag, logic obs, logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic probe(string tag, int sx, int sy, logic exp);
    @(negedge clk);
    scan_x = 10'(sx);
    scan_y = 9'(sy);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(tag, draw, exp_q.pop_front());
  endtask

  task automatic probe_model(string tag, int sx, int sy);
    probe(tag, sx, sy, model_draw(sx, sy));
  endtask

  task automatic rand_probes(string tag, int n);
    int sx, sy;
    for (int i = 0; i < n; i++) begin
      sx = X0 - 8 + int'($urandom_range(0, 180));
      sy = Y0 + m_offset() - 8 + int'($urandom_range(0, 40));
      probe_model(tag, sx, sy);
    end
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      if (m_active) m_t++;
    end
  endtask

  task automatic start_banner(logic [1:0] res);
    @(negedge clk);
    show = 1'b1;
    result = res;
    @(negedge clk);
    m_active = 1'b1;
    m_t = 0;
    m_word = (res == 2'd3) ? "TIE" : ((res == 2'd1) ? "X WIN" : "O WIN");
  endtask

  task automatic stop_banner();
    @(negedge clk);
    show = 1'b0;
    @(negedge clk);
    m_active = 1'b0;
  endtask

  task automatic check_busy(string tag);
    @(negedge clk);
    check(tag, busy, m_busy());
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("reset_draw", draw, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;
    probe("idle_noshow", 100, 200, 1'b0);

    // TIE: entry of slide, offset START
    start_banner(2'd3);
    check_busy("slide_busy");
    probe("slide_entry_on", 100, 264, 1'b1);
    probe("slide_entry_off", 100, 200, 1'b0);
    tick(8);
    probe("slide_mid_on", 100, 232, 1'b1);
    rand_probes("slide_mid_rand", 12);
    tick(7);
    check_busy("slide_last_busy");
    tick(1);
    check_busy("settled_busy");

    // TIE settled, directed pixels and one-clock latency
    probe("tie_t_row0", 100, 200, 1'b1);
    @(negedge clk);
    scan_x = 10'd121;
    #1;
    check("lag_hold", draw, 1'b1);
    @(posedge clk);
    #1;
    check("tie_gap", draw, 1'b0);
    probe("tie_i_row0", 136, 200, 1'b1);
    probe("tie_i_edge", 132, 200, 1'b0);
    rand_probes("tie_rand", 24);

    // blink
    tick(BLINK - 1);
    probe("blink_still_on", 100, 200, 1'b1);
    tick(1);
    probe("blink_off", 100, 200, 1'b0);
    rand_probes("blink_off_rand", 10);
    tick(BLINK);
    probe("blink_back_on", 100, 200, 1'b1);
    stop_banner();
    probe("idle_after_stop", 100, 200, 1'b0);

    // async reset mid-slide
    start_banner(2'd3);
    tick(3);
    probe("pre_reset_on", 100, 252, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_draw", draw, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    show = 1'b0;
    m_active = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_busy", busy, 1'b0);
    probe("post_reset_idle", 100, 264, 1'b0);

    // show drops together with frame_tick mid-slide
    start_banner(2'd3);
    tick(2);
    @(negedge clk);
    show = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    m_active = 1'b0;
    check("drop_busy", busy, 1'b0);
    probe("drop_idle", 100, 256, 1'b0);
    start_banner(2'd3);
    check_busy("restart_busy");
    probe("restart_on", 100, 264, 1'b1);
    probe("restart_off", 100, 256, 1'b0);
    stop_banner();

    // X WIN
    start_banner(2'd1);
    tick(NSLIDE);
    check_busy("xwin_busy");
    probe("xwin_row0", 100, 200, 1'b1);
    probe("xwin_row0_gap", 108, 200, 1'b0);
    probe("xwin_row2", 104, 208, 1'b1);
    probe("xwin_space", 140, 200, 1'b0);
    rand_probes("xwin_rand", 24);
    @(negedge clk);
    result = 2'd2;
    probe("xwin_relatch", 100, 200, 1'b1);
    rand_probes("xwin_relatch_rand", 8);
    stop_banner();

    // O WIN
    start_banner(2'd2);
    rand_probes("owin_slide_rand", 8);
    tick(NSLIDE);
    probe("owin_row0_l", 100, 200, 1'b0);
    probe("owin_row0_m", 104, 200, 1'b1);
    rand_probes("owin_rand", 24);
    stop_banner();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
